pio_event_controller: RTL and testbench

PIO_EVENT_CONTROLLER -- requirements
Module: pio_event_controller

---
 rtl/pio_evt_pkg.sv | 19 +
 rtl/pio_evt_fifo.sv | 49 ++++
 rtl/pio_event_controller.sv | 163 ++++++++++++++++
 tb/tb_pio_event_controller.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_evt_pkg.sv
// Shared state encoding and PIO register map for the PIO event controller.
package pio_evt_pkg;

  typedef enum logic [2:0] {
    DISABLED,
    MASK_ON,
    IDLE,
    RD_ADDR,
    RD_DATA,
    CLR,
    DISPATCH,
    MASK_OFF
  } state_e;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

endpackage

// File: rtl/pio_evt_fifo.sv
// First-word-fall-through FIFO; accepts a push while full when a pop happens in the same cycle.
module pio_evt_fifo #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign pop_data = mem_q[rd_q];

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push) mem_q[wr_q] <= push_data;
    end
  end

endmodule

// File: rtl/pio_event_controller.sv
// Services PIO edge-capture interrupts: arms the mask, reads and clears edges,
// and queues the index of each captured edge in round-robin order.
module pio_event_controller
  import pio_evt_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 5,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned CW        = $clog2(NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [NUM_INPUTS-1:0] mask_cfg,
  input  logic                  pio_irq,
  output logic [1:0]            m_address,
  output logic                  m_chipselect,
  output logic                  m_write_n,
  output logic [31:0]           m_writedata,
  input  logic [31:0]           m_readdata,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [CW-1:0]         evt_code,
  output logic [15:0]           evt_count
);

  state_e                state_q, state_d;
  logic [NUM_INPUTS-1:0] pending_q, pending_d;
  logic [CW-1:0]         rr_q, rr_d;
  logic [1:0]            addr_q, addr_d;
  logic                  cs_q, cs_d;
  logic                  wn_q, wn_d;
  logic [31:0]           wd_q, wd_d;
  logic [15:0]           count_q, count_d;

  logic                  fifo_full, fifo_empty;
  logic                  push_c, pop_c;
  logic [CW-1:0]         grant_c;
  int unsigned           idx;
  logic                  found;

  assign evt_valid    = !fifo_empty;
  assign pop_c        = evt_valid && evt_ready;
  assign m_address    = addr_q;
  assign m_chipselect = cs_q;
  assign m_write_n    = wn_q;
  assign m_writedata  = wd_q;
  assign evt_count    = count_q;

  // Lowest pending bit at or above rr_q, wrapping to bit 0.
  always_comb begin
    grant_c = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
      if (!found && pending_q[CW'(idx)]) begin
        found   = 1'b1;
        grant_c = CW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    rr_d      = rr_q;
    push_c    = 1'b0;
    count_d   = count_q + 16'(pop_c);
    addr_d    = PIO_ADDR_DATA;
    cs_d      = 1'b0;
    wn_d      = 1'b1;
    wd_d      = '0;

    case (state_q)
      DISABLED: if (enable) state_d = MASK_ON;
      MASK_ON:  state_d = IDLE;
      IDLE: begin
        if (!enable)      state_d = MASK_OFF;
        else if (pio_irq) state_d = RD_ADDR;
      end
      RD_ADDR:  state_d = RD_DATA;
      RD_DATA: begin
        pending_d = m_readdata[NUM_INPUTS-1:0] & mask_cfg;
        state_d   = CLR;
      end
      CLR:      state_d = (pending_q != '0) ? DISPATCH : IDLE;
      DISPATCH: begin
        if (!fifo_full || pop_c) begin
          push_c    = 1'b1;
          pending_d = pending_q & ~(NUM_INPUTS'(1) << grant_c);
          rr_d      = (grant_c == CW'(NUM_INPUTS - 1)) ? '0 : grant_c + CW'(1);
          if (pending_d == '0) state_d = IDLE;
        end
      end
      MASK_OFF: state_d = DISABLED;
      default:  state_d = DISABLED;
    endcase

    // Bus outputs are registered alongside the state they belong to.
    case (state_d)
      MASK_ON: begin
        addr_d = PIO_ADDR_MASK;
        cs_d   = 1'b1;
        wn_d   = 1'b0;
        wd_d   = 32'(mask_cfg);
      end
      MASK_OFF: begin
        addr_d = PIO_ADDR_MASK;
        cs_d   = 1'b1;
        wn_d   = 1'b0;
      end
      RD_ADDR, RD_DATA: begin
        addr_d = PIO_ADDR_EDGE;
        cs_d   = 1'b1;
      end
      CLR: begin
        addr_d = PIO_ADDR_EDGE;
        cs_d   = 1'b1;
        wn_d   = 1'b0;
        wd_d   = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= DISABLED;
      pending_q <= '0;
      rr_q      <= '0;
      addr_q    <= PIO_ADDR_DATA;
      cs_q      <= 1'b0;
      wn_q      <= 1'b1;
      wd_q      <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      addr_q    <= addr_d;
      cs_q      <= cs_d;
      wn_q      <= wn_d;
      wd_q      <= wd_d;
      count_q   <= count_d;
    end
  end

  pio_evt_fifo #(
    .WIDTH (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_c),
    .push_data (grant_c),
    .pop       (pop_c),
    .pop_data  (evt_code),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_pio_event_controller.sv
// Directed bench: PIO register model, round-robin scoreboard and bus/timing checks.
module tb_pio_event_controller;

  localparam int NI = 5;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [NI-1:0] mask_cfg;
  logic          pio_irq;
  logic [1:0]    m_address;
  logic          m_chipselect;
  logic          m_write_n;
  logic [31:0]   m_writedata;
  logic [31:0]   m_readdata = '0;
  logic          evt_valid;
  logic          evt_ready;
  logic [CW-1:0] evt_code;
  logic [15:0]   evt_count;

  pio_event_controller #(.NUM_INPUTS(NI), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .mask_cfg     (mask_cfg),
    .pio_irq      (pio_irq),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_code     (evt_code),
    .evt_count    (evt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  a;
    logic [31:0] d;
    int          c;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        chk_on = 1'b0;
  logic [NI-1:0] edge_reg = '0;
  wr_t         wr_log[$];
  int          rd_cnt, first_rd, first_vld;
  int          exp_q[$];
  int          last_q[$];
  int          mdl_rr = 0;
  logic [15:0] mdl_cnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // PIO edge_capture register: read data appears one cycle after the address.
  always @(posedge clk)
    if (m_chipselect && m_write_n && m_address == 2'd3) m_readdata <= 32'(edge_reg);
    else m_readdata <= '0;

  task automatic clear_log();
    wr_log.delete();
    rd_cnt    = 0;
    first_rd  = -1;
    first_vld = -1;
  endtask

  // Round-robin grant order: first set bit at or above the pointer, else from bit 0.
  task automatic model_dispatch(input logic [NI-1:0] pend);
    logic [NI-1:0] p;
    int f;
    p = pend;
    last_q.delete();
    while (p != '0) begin
      f = -1;
      for (int i = mdl_rr; i < NI; i++) if (f < 0 && p[i]) f = i;
      for (int i = 0; i < mdl_rr; i++) if (f < 0 && p[i]) f = i;
      p[f] = 1'b0;
      exp_q.push_back(f);
      last_q.push_back(f);
      mdl_rr = (f + 1) % NI;
    end
  endtask

  // Per-cycle checks on bus idle values, event codes and delivered count.
  always @(negedge clk) begin
    if (chk_on) begin
      if (!m_chipselect)
        chk("bus_idle", {m_address, m_write_n, m_writedata}, {2'd0, 1'b1, 32'd0});
      if (m_chipselect && !m_write_n) wr_log.push_back('{m_address, m_writedata, cyc});
      if (m_chipselect && m_write_n) begin
        if (rd_cnt == 0) first_rd = cyc;
        rd_cnt++;
      end
      if (evt_valid && first_vld < 0) first_vld = cyc;
      chk("evt_count", evt_count, mdl_cnt);
      if (evt_valid) begin
        if (exp_q.size() == 0) chk("evt_unexpected", evt_valid, 0);
        else begin
          chk("evt_code", evt_code, exp_q[0]);
          if (evt_ready) begin
            void'(exp_q.pop_front());
            mdl_cnt++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    mdl_cnt = '0;
    mdl_rr  = 0;
  endtask

  task automatic do_reset();
    chk_on  = 1'b0;
    reset_n = 1'b0;
    enable  = 1'b0;
    pio_irq = 1'b0;
    evt_ready = 1'b1;
    repeat (3) tick();
    chk("rst_cs", m_chipselect, 0);
    chk("rst_wn", m_write_n, 1);
    chk("rst_addr", m_address, 0);
    chk("rst_wd", m_writedata, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_code", evt_code, 0);
    chk("rst_count", evt_count, 0);
    model_reset();
    clear_log();
    reset_n = 1'b1;
    chk_on  = 1'b1;
  endtask

  task automatic irq_pulse(output int n);
    n = cyc;
    pio_irq = 1'b1;
    tick();
    pio_irq = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    repeat (3) tick();
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic chk_write(input string name, input int idx, input logic [1:0] a,
                           input logic [31:0] d, input int c);
    if (wr_log.size() > idx) begin
      chk({name, "_addr"}, wr_log[idx].a, a);
      chk({name, "_data"}, wr_log[idx].d, d);
      chk({name, "_cyc"}, wr_log[idx].c, c);
    end else chk({name, "_missing"}, wr_log.size(), idx + 1);
  endtask

  int n, m, rd0;

  initial begin
    reset_n = 1'b0; enable = 1'b0; pio_irq = 1'b0; evt_ready = 1'b1; mask_cfg = '0;
    do_reset();

    // Arm the mask.
    mask_cfg = 5'h1F;
    enable = 1'b1;
    m = cyc;
    repeat (4) tick();
    chk("mask_on_writes", wr_log.size(), 1);
    chk_write("mask_on", 0, 2'd2, 32'h1F, m + 1);
    chk("mask_on_no_read", rd_cnt, 0);

    // Two edges, consumer ready.
    clear_log();
    edge_reg = 5'b10100;
    model_dispatch(edge_reg);
    chk("s2_order0", last_q[0], 2);
    chk("s2_order1", last_q[1], 4);
    irq_pulse(n);
    wait_drain();
    chk("s2_first_rd", first_rd, n + 1);
    chk("s2_writes", wr_log.size(), 1);
    chk_write("s2_clr", 0, 2'd3, 32'hFFFF_FFFF, n + 3);
    chk("s2_first_valid", first_vld, n + 5);
    chk("s2_count", evt_count, 2);

    // Move pointer to 3, then grant 3, 4, 0.
    edge_reg = 5'b00100;
    model_dispatch(edge_reg);
    irq_pulse(n);
    wait_drain();
    edge_reg = 5'b11001;
    model_dispatch(edge_reg);
    chk("s3_order0", last_q[0], 3);
    chk("s3_order1", last_q[1], 4);
    chk("s3_order2", last_q[2], 0);
    irq_pulse(n);
    wait_drain();
    chk("s3_count", evt_count, 6);

    // Stall on a full FIFO, then drain.
    evt_ready = 1'b0;
    edge_reg = 5'b11111;
    model_dispatch(edge_reg);
    chk("s4_order0", last_q[0], 1);
    chk("s4_order4", last_q[4], 0);
    clear_log();
    irq_pulse(n);
    repeat (12) tick();
    chk("s4_valid", evt_valid, 1);
    chk("s4_code_head", evt_code, 1);
    chk("s4_count_held", evt_count, 6);
    rd0 = rd_cnt;
    pio_irq = 1'b1;
    repeat (3) tick();
    pio_irq = 1'b0;
    tick();
    chk("s4_stall_no_read", rd_cnt, rd0);
    chk("s4_writes", wr_log.size(), 1);
    evt_ready = 1'b1;
    wait_drain();
    chk("s4_count", evt_count, 11);
    chk("s4_no_reread", rd_cnt, rd0);

    // Masked-off edge: read and clear only.
    mask_cfg = 5'b11101;
    edge_reg = 5'b00010;
    clear_log();
    irq_pulse(n);
    repeat (8) tick();
    chk("s5_first_rd", first_rd, n + 1);
    chk("s5_writes", wr_log.size(), 1);
    chk_write("s5_clr", 0, 2'd3, 32'hFFFF_FFFF, n + 3);
    chk("s5_no_evt", first_vld, -1);
    edge_reg = 5'b00001;
    model_dispatch(edge_reg);
    chk("s5b_order0", last_q[0], 0);
    clear_log();
    irq_pulse(n);
    wait_drain();
    chk("s5b_first_rd", first_rd, n + 1);
    chk("s5b_count", evt_count, 12);

    // Disable wins over irq in the same cycle.
    clear_log();
    n = cyc;
    enable = 1'b0;
    pio_irq = 1'b1;
    repeat (5) tick();
    pio_irq = 1'b0;
    chk("s6_writes", wr_log.size(), 1);
    chk_write("s6_mask_off", 0, 2'd2, 32'h0, n + 1);
    chk("s6_no_read", rd_cnt, 0);
    clear_log();
    enable = 1'b1;
    m = cyc;
    repeat (4) tick();
    chk_write("s6_rearm", 0, 2'd2, 32'h1D, m + 1);

    // Reset during the read data cycle aborts the access.
    edge_reg = 5'b11111;
    irq_pulse(n);
    tick();
    chk_on = 1'b0;
    reset_n = 1'b0;
    enable = 1'b0;
    tick();
    model_reset();
    clear_log();
    tick();
    reset_n = 1'b1;
    chk_on = 1'b1;
    pio_irq = 1'b1;
    repeat (6) tick();
    pio_irq = 1'b0;
    chk("s7_no_write", wr_log.size(), 0);
    chk("s7_no_read", rd_cnt, 0);
    chk("s7_count", evt_count, 0);
    chk("s7_valid", evt_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
